level_to_pulse: RTL and testbench

- Inverse of the status-LED pulse extender: converts a slow or asynchronous level input into clean one-clock event pulses.
- Typical inputs are front-panel buttons, external trigger/PPS levels and cable-detect lines.
- Pipeline: synchronizes the input, debounces it with a qualification counter, then emits single-cycle rise/fall strobes plus a debounced level.
- Keeps a saturating count of qualified rising events for status readout.

---
 rtl/level_to_pulse.sv | 155 +++++++++++++++
 tb/tb_level_to_pulse.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/level_to_pulse.sv
// level_to_pulse: synchronizes and debounces a slow level, then emits
// one-cycle rise/fall strobes, the clean level and a rising-event count.
module level_to_pulse #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 80000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 level_in,
  input  logic                 cnt_clr,
  output logic                 level_out,
  output logic                 pulse_rise,
  output logic                 pulse_fall,
  output logic [CNT_WIDTH-1:0] rise_count
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_LAST = QW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    Q_HIGH,
    HIGH,
    Q_LOW
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [QW-1:0]          q_cnt_q, q_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw level through the synchronizer chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], level_in};
  end

  // Qualification FSM: a level change must be seen on every sample
  // for DEBOUNCE_CYCLES samples; any opposite sample restarts it.
  // With single-sample qualification a change right after a strobe
  // is held off one cycle so strobes can never be back to back.
  always_comb begin
    state_d = state_q;
    q_cnt_d = q_cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      LOW: begin
        if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            if (!fall_q) begin
              state_d = HIGH;
              level_d = 1'b1;
              rise_d  = 1'b1;
            end
          end else begin
            state_d = Q_HIGH;
            q_cnt_d = Q_ONE;
          end
        end
      end
      Q_HIGH: begin
        if (!s) begin
          state_d = LOW;
          q_cnt_d = '0;
        end else if (q_cnt_q == Q_LAST) begin
          state_d = HIGH;
          q_cnt_d = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          q_cnt_d = q_cnt_q + Q_ONE;
        end
      end
      HIGH: begin
        if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            if (!rise_q) begin
              state_d = LOW;
              level_d = 1'b0;
              fall_d  = 1'b1;
            end
          end else begin
            state_d = Q_LOW;
            q_cnt_d = Q_ONE;
          end
        end
      end
      Q_LOW: begin
        if (s) begin
          state_d = HIGH;
          q_cnt_d = '0;
        end else if (q_cnt_q == Q_LAST) begin
          state_d = LOW;
          q_cnt_d = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          q_cnt_d = q_cnt_q + Q_ONE;
        end
      end
      default: begin
        state_d = LOW;
        q_cnt_d = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // Count visible rise strobes; a clear that coincides with one
  // leaves that rise counted.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = CNT_WIDTH'(rise_q);
    end else if (rise_q && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // All state and outputs registered, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= LOW;
      q_cnt_q <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      q_cnt_q <= q_cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_out  = level_q;
  assign pulse_rise = rise_q;
  assign pulse_fall = fall_q;
  assign rise_count = cnt_q;

endmodule

// File: tb/tb_level_to_pulse.sv
// tb_level_to_pulse: scoreboard bench for a D=4 build and a D=1
// build of level_to_pulse.
module tb_level_to_pulse;

  localparam logic [1:0] RISE = 2'b10;
  localparam logic [1:0] FALL = 2'b01;

  typedef struct {
    logic [1:0] kind;
    int         at;
  } ev_t;

  typedef struct {
    string name;
    bit    dut;
    bit    lvl;
    int    cnt;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        level_a, level_b, clr_a;
  logic        lvl_a, pr_a, pf_a;
  logic        lvl_b, pr_b, pf_b;
  logic [3:0]  rc_a;
  logic [15:0] rc_b;

  int   edge_n = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;
  ev_t  exp_a[$];
  ev_t  exp_b[$];
  chk_t chk_q[$];

  level_to_pulse #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(4)
  ) u_a (
    .clk(clk), .rst(rst), .level_in(level_a), .cnt_clr(clr_a),
    .level_out(lvl_a), .pulse_rise(pr_a), .pulse_fall(pf_a),
    .rise_count(rc_a)
  );

  level_to_pulse #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_WIDTH(16)
  ) u_b (
    .clk(clk), .rst(rst), .level_in(level_b), .cnt_clr(1'b0),
    .level_out(lvl_b), .pulse_rise(pr_b), .pulse_fall(pf_b),
    .rise_count(rc_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input bit dut, input logic [1:0] k,
                           input int dly);
    ev_t e;
    e.kind = k;
    e.at   = edge_n + dly;
    if (dut) exp_b.push_back(e);
    else     exp_a.push_back(e);
  endtask

  task automatic check(input string n, input bit dut, input bit lvl,
                       input int cnt);
    chk_t c;
    c.name = n;
    c.dut  = dut;
    c.lvl  = lvl;
    c.cnt  = cnt;
    chk_q.push_back(c);
    tick(2);
  endtask

  // Monitor: pops expectations when a strobe appears or a status
  // check is queued, and closes the run.
  ev_t  m_e;
  chk_t m_c;
  always @(negedge clk) begin
    if (pr_a | pf_a) begin
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_a: unexpected {r,f}=%b at edge %0d",
                 {pr_a, pf_a}, edge_n);
      end else begin
        m_e = exp_a.pop_front();
        if (m_e.kind != {pr_a, pf_a} || m_e.at != edge_n) begin
          n_bad++;
          $display("FAIL strobe_a: got {r,f}=%b @%0d want %b @%0d",
                   {pr_a, pf_a}, edge_n, m_e.kind, m_e.at);
        end
      end
    end
    if (pr_b | pf_b) begin
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_bad++;
        $display("FAIL strobe_b: unexpected {r,f}=%b at edge %0d",
                 {pr_b, pf_b}, edge_n);
      end else begin
        m_e = exp_b.pop_front();
        if (m_e.kind != {pr_b, pf_b} || m_e.at != edge_n) begin
          n_bad++;
          $display("FAIL strobe_b: got {r,f}=%b @%0d want %b @%0d",
                   {pr_b, pf_b}, edge_n, m_e.kind, m_e.at);
        end
      end
    end
    if (chk_q.size() > 0) begin
      m_c = chk_q.pop_front();
      n_cmp++;
      if (!m_c.dut) begin
        if (lvl_a != m_c.lvl || pr_a || pf_a
            || int'(rc_a) != m_c.cnt) begin
          n_bad++;
          $display("FAIL %s: got lvl=%0b r=%0b f=%0b cnt=%0d want lvl=%0b r=0 f=0 cnt=%0d",
                   m_c.name, lvl_a, pr_a, pf_a, rc_a, m_c.lvl, m_c.cnt);
        end
      end else begin
        if (lvl_b != m_c.lvl || pr_b || pf_b
            || int'(rc_b) != m_c.cnt) begin
          n_bad++;
          $display("FAIL %s: got lvl=%0b r=%0b f=%0b cnt=%0d want lvl=%0b r=0 f=0 cnt=%0d",
                   m_c.name, lvl_b, pr_b, pf_b, rc_b, m_c.lvl, m_c.cnt);
        end
      end
    end
    if (done && chk_q.size() == 0) begin
      n_cmp++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
        n_bad++;
        $display("FAIL missing_strobes: got %0d/%0d pending want 0/0",
                 exp_a.size(), exp_b.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
    end
    if (edge_n > 20000) begin
      n_bad++;
      $display("FAIL timeout: got edge %0d want done by 20000", edge_n);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
    end
  end

  // Stimulus
  initial begin
    int e_clr;
    rst     = 1'b1;
    level_a = 1'b0;
    level_b = 1'b0;
    clr_a   = 1'b0;
    tick(3);
    check("reset_a", 1'b0, 1'b0, 0);
    check("reset_b", 1'b1, 1'b0, 0);
    rst = 1'b0;
    tick(3);

    level_a = 1'b1;
    expect_ev(1'b0, RISE, 6);
    tick(10);
    check("clean_rise", 1'b0, 1'b1, 1);

    level_a = 1'b0;
    tick(2);
    level_a = 1'b1;
    tick(1);
    level_a = 1'b0;
    expect_ev(1'b0, FALL, 6);
    tick(10);
    check("fall_path", 1'b0, 1'b0, 1);

    level_a = 1'b1;
    tick(3);
    level_a = 1'b0;
    tick(6);
    check("glitch_reject", 1'b0, 1'b0, 1);
    level_a = 1'b1;
    expect_ev(1'b0, RISE, 6);
    tick(10);
    check("rise_after_glitch", 1'b0, 1'b1, 2);
    level_a = 1'b0;
    expect_ev(1'b0, FALL, 6);
    tick(10);

    for (int i = 0; i < 20; i++) begin
      level_a = 1'b1;
      expect_ev(1'b0, RISE, 6);
      tick(8);
      level_a = 1'b0;
      expect_ev(1'b0, FALL, 6);
      tick(8);
    end
    tick(2);
    check("saturate", 1'b0, 1'b0, 15);

    level_a = 1'b1;
    e_clr = edge_n + 6;
    expect_ev(1'b0, RISE, 6);
    for (int i = 0; i < 20 && edge_n != e_clr; i++) tick(1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("clr_with_rise", 1'b0, 1'b1, 1);
    clr_a = 1'b1;
    tick(1);
    clr_a = 1'b0;
    check("clr_only", 1'b0, 1'b1, 0);
    level_a = 1'b0;
    expect_ev(1'b0, FALL, 6);
    tick(10);

    level_a = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("rst_midq", 1'b0, 1'b0, 0);
    rst = 1'b0;
    expect_ev(1'b0, RISE, 6);
    tick(12);
    check("requalify", 1'b0, 1'b1, 1);

    for (int i = 0; i < 6; i++) begin
      level_b = ~level_b;
      expect_ev(1'b1, level_b ? RISE : FALL, 3);
      tick(3);
    end
    tick(5);
    check("d1_final", 1'b1, 1'b0, 3);

    done = 1'b1;
  end

endmodule
